// File: rtl/mix_addr_xfer_ctrl.sv
// Sequencer for MIX INCr/DECr/ENTr/ENNr (C=48..55): read register, run datapath, write back.
// Optional MIX_XFER_ENT_FAST_EN: legal ENT/ENN skip READ/EXEC and finish the cycle after start.
module mix_addr_xfer_ctrl #(
  parameter int REG_W    = 31,
  parameter int IDX_BITS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [2:0]       field,
  input  logic [12:0]      m,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             idx_fault,
  output logic [2:0]       rf_raddr,
  input  logic [REG_W-1:0] rf_rdata,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [REG_W-1:0] rf_wdata,
  output logic [REG_W-1:0] dp_in,
  output logic [12:0]      dp_m,
  output logic [1:0]       dp_field,
  input  logic [REG_W-1:0] dp_out,
  input  logic             dp_overflow,
  output logic             ov_flag,
  input  logic             ov_clr
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t             state, state_nx;
  logic [2:0]         r_q;
  logic [1:0]         field_q;
  logic [12:0]        m_q;
  logic               illegal_q;
  logic [REG_W-1:0]   result_q;
  logic [REG_W-1:0]   in_q;
  logic               ovf_q;

  logic start_bad;
  logic fast_go;
  logic is_idx;
  logic out_of_range;
  logic ov_set;

  assign start_bad = (opcode < 6'd48) || (opcode > 6'd55) || field[2];

`ifdef MIX_XFER_ENT_FAST_EN
  assign fast_go = (state == IDLE) && start && !start_bad && field[1];
`else
  assign fast_go = 1'b0;
`endif

  // Register 0 is A and 7 is X; only I1..I6 are range-limited index registers.
  assign is_idx       = (r_q != 3'd0) && (r_q != 3'd7);
  assign out_of_range = |result_q[REG_W-2:IDX_BITS];
  assign ov_set       = (state == WRITE) && !illegal_q && !is_idx && ovf_q && !rst;

  assign rf_raddr = r_q;
  assign rf_waddr = r_q;
  assign rf_wdata = result_q;

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    idx_fault = 1'b0;
    rf_we     = 1'b0;
    dp_in     = in_q;
    dp_m      = m_q;
    dp_field  = field_q;
    case (state)
      IDLE: begin
        if (start) state_nx = (start_bad || fast_go) ? WRITE : READ;
        if (fast_go) begin
          dp_in    = '0;
          dp_m     = m;
          dp_field = field[1:0];
        end
      end
      READ: state_nx = EXEC;
      EXEC: begin
        dp_in    = rf_rdata;
        state_nx = WRITE;
      end
      WRITE: begin
        // Outputs are masked while reset is held so a reset in WRITE writes nothing.
        done      = !rst;
        illegal   = illegal_q && !rst;
        idx_fault = !illegal_q && is_idx && out_of_range && !rst;
        rf_we     = !illegal_q && !(is_idx && out_of_range) && !rst;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_q       <= '0;
      field_q   <= '0;
      m_q       <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      in_q      <= '0;
      ovf_q     <= 1'b0;
      ov_flag   <= 1'b0;
    end else begin
      state <= state_nx;
      if (ov_set)      ov_flag <= 1'b1;
      else if (ov_clr) ov_flag <= 1'b0;

      if (state == IDLE && start) begin
        // 48 is a multiple of 8, so opcode-48 for legal opcodes is just opcode[2:0].
        r_q       <= opcode[2:0];
        field_q   <= field[1:0];
        m_q       <= m;
        illegal_q <= start_bad;
        if (fast_go) begin
          in_q     <= '0;
          result_q <= dp_out;
          ovf_q    <= dp_overflow;
        end
      end

      if (state == EXEC) begin
        in_q     <= rf_rdata;
        result_q <= dp_out;
        ovf_q    <= dp_overflow;
      end
    end
  end

endmodule

// File: doc/mix_addr_xfer_ctrl.md
Name: mix_addr_xfer_ctrl

Overview:
Sequencer for the MIX address-transfer instruction group, opcodes 48-55 (INCr/DECr/ENTr/ENNr).
- Latches one instruction per start pulse.
- Reads the target register, drives the combinational inc/dec/ent/enn datapath and writes the result back.
- Maintains the overflow toggle and rejects out-of-range index results.
- Sits between the instruction decoder, the 8-entry register file (A, I1-I6, X) and the address-transfer datapath.

Parameters:
REG_W, 31, register word width: sign bit [30] plus 5 six-bit bytes.
IDX_BITS, 12, magnitude bits legal in an index register (2 bytes).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  issue pulse; sampled only in IDLE
opcode  in  6  C field, legal 48..55
field  in  3  F field: 0 INC, 1 DEC, 2 ENT, 3 ENN
m  in  13  effective address, sign [12] + magnitude [11:0]
busy  out  1  high while an instruction is in flight
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle pulse, coincident with done, for bad C/F
idx_fault  out  1  one-cycle pulse, coincident with done, for index out of range
rf_raddr  out  3  register file read address
rf_rdata  in  31  read data, valid one cycle after rf_raddr
rf_we  out  1  write enable
rf_waddr  out  3  write address
rf_wdata  out  31  write data
dp_in  out  31  datapath operand
dp_m  out  13  datapath address operand
dp_field  out  2  datapath function select
dp_out  in  31  datapath result, combinational
dp_overflow  in  1  datapath overflow, combinational
ov_flag  out  1  MIX overflow toggle
ov_clr  in  1  clears ov_flag (driven by JOV/JNOV logic)

Behaviour:
- Reset: state IDLE. busy, done, illegal, idx_fault, rf_we and ov_flag = 0. Latched operands = 0.
- Register index r = opcode-48. Encoding: 0=A, 1..6=I1..I6, 7=X. rf_raddr = rf_waddr = r.
- States: IDLE, READ, EXEC, WRITE.
- IDLE:
  - On start, latch opcode/field/m.
  - If opcode outside 48..55 or field>3, go to WRITE with illegal flagged. No register write.
  - Otherwise go to READ.
  - start while busy is ignored.
- READ: drive rf_raddr. rf_rdata arrives next cycle.
- EXEC: drive dp_in = rf_rdata, dp_m = m, dp_field = field[1:0]. Register dp_out into result and dp_overflow into ovf.
- WRITE: done = 1 for one cycle.
  - rf_we = 1 with rf_wdata = result, unless illegal or idx_fault.
  - Then IDLE.
- Latency: start at cycle T gives busy at T+1..T+3 and done/rf_we at T+3. Next start is accepted at T+4. Throughput is 1 instruction per 4 cycles.
- ENT/ENN follow the same path; rf_rdata is don't-care.
- dp_in, dp_m and dp_field hold their latched values outside EXEC.
- Index registers (r=1..6):
  - If result[29:IDX_BITS] is nonzero, pulse idx_fault and suppress the write.
  - ov_flag is not affected by index registers.
- A and X (r=0,7): ovf=1 sets ov_flag in WRITE. The written value is the datapath result (wrapped magnitude).
- ov_flag:
  - ov_clr clears it in any state.
  - If set and ov_clr occur in the same cycle, set wins.
  - ov_flag holds otherwise.
- Minus zero produced by the datapath is written unchanged.
- Reset asserted in any state returns to IDLE next cycle: no write, no done, ov_flag cleared.

Optional Feature:
MIX_XFER_ENT_FAST_EN:
- Defined: legal ENT/ENN (field 2/3) go IDLE->WRITE directly. The result is computed in the start cycle from m via the datapath with dp_in = 0. done/rf_we at T+1, busy only at T+1. INC/DEC are unchanged.
- Undefined: all opcodes use the uniform 3-cycle path.

Test Plan:
- A=+5 (31'h00000005), start C=48 F=0 m=+3 -> rf_we/done at T+3, rf_waddr=0, rf_wdata=31'h00000008, ov_flag=0.
- A={1,30'h3FFFFFFF}, C=48 F=1 m=+1 -> wrap value written to A, ov_flag=1 at T+4. Then ov_clr pulse -> ov_flag=0; ov_clr coincident with a new overflow set -> ov_flag=1.
- I1=+4095, C=49 F=0 m=+1 -> idx_fault and done at T+3, rf_we=0, ov_flag unchanged.
- C=55 F=3 m=+0 -> X written 31'h40000000 (minus zero). C=47 -> illegal at T+1 when fast feature on, else at T+1 via WRITE, rf_we=0.
- rst asserted while in EXEC -> IDLE next cycle, no rf_we, no done. start asserted while busy is ignored.
- MIX_XFER_ENT_FAST_EN defined: C=50 F=2 m=-7 -> I2=31'h40000007 with done at T+1. INC timing is still T+3.
